// File: rtl/gray_decoder.sv
// Registered Gray-to-binary decoder with a single-step tracker.
// Flags consecutive samples that are neither equal nor one code step apart.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_FIRST  | no step reference; next sample only loads prev_bin
// ST_TRACK  | each sample is compared against prev_bin (delta 0/+1/-1)
module gray_decoder #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             clear,
    output logic             out_valid,
    output logic [WIDTH-1:0] bin_out,
    output logic [1:0]       dir,
    output logic             step_err,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [0:0] ST_FIRST = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;

    localparam logic [WIDTH-1:0] DELTA_UP   = WIDTH'(1);
    localparam logic [WIDTH-1:0] DELTA_DOWN = '1;
    localparam logic [ERR_W-1:0] ERR_MAX    = '1;

    logic             s1_v;
    logic [WIDTH-1:0] s1_gray;
    logic [WIDTH-1:0] s1_bin;
    logic [WIDTH-1:0] prev_bin;
    logic [WIDTH-1:0] delta;
    logic [0:0]       state;
    logic [1:0]       dir_nxt;
    logic             err_nxt;

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        s1_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s1_bin[i] = ^(s1_gray >> i);
        end
    end

    assign delta = s1_bin - prev_bin;

    // A same-edge clear forces the sample to be reported as a first sample.
    always_comb begin
        dir_nxt = 2'b00;
        err_nxt = 1'b0;
        if (state == ST_TRACK && !clear) begin
            if (delta == '0) begin
                dir_nxt = 2'b00;
            end else if (delta == DELTA_UP) begin
                dir_nxt = 2'b01;
            end else if (delta == DELTA_DOWN) begin
                dir_nxt = 2'b10;
            end else begin
                dir_nxt = 2'b11;
                err_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v      <= 1'b0;
            s1_gray   <= '0;
            out_valid <= 1'b0;
            bin_out   <= '0;
            dir       <= 2'b00;
            step_err  <= 1'b0;
            err_count <= '0;
            prev_bin  <= '0;
            state     <= ST_FIRST;
        end else begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_gray <= gray_in;
            end

            out_valid <= s1_v;
            dir       <= s1_v ? dir_nxt : 2'b00;
            step_err  <= s1_v & err_nxt;

            // prev_bin follows every sample, so a bad step resynchronizes.
            if (s1_v) begin
                bin_out  <= s1_bin;
                prev_bin <= s1_bin;
            end

            if (clear) begin
                state     <= ST_FIRST;
                err_count <= '0;
            end else if (s1_v) begin
                state <= ST_TRACK;
                if (err_nxt && err_count != ERR_MAX) begin
                    err_count <= err_count + ERR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_gray_decoder.sv
// Self-checking bench for gray_decoder: directed scenarios plus a randomized
// stream compared against an arithmetic model of the step tracker.
module tb_gray_decoder;

    localparam int WIDTH = 4;
    localparam int ERR_W = 2;
    localparam int MOD   = 1 << WIDTH;
    localparam int CMAX  = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] gray_in = '0;
    logic             clear = 1'b0;
    logic             out_valid;
    logic [WIDTH-1:0] bin_out;
    logic [1:0]       dir;
    logic             step_err;
    logic [ERR_W-1:0] err_count;

    int checks = 0;
    int errors = 0;

    // model state for the randomized stream
    bit m_first;
    int m_prev;
    int m_cnt;

    gray_decoder #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .gray_in(gray_in),
        .clear(clear), .out_valid(out_valid), .bin_out(bin_out), .dir(dir),
        .step_err(step_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] b2g(input int b);
        int bm;
        bm = ((b % MOD) + MOD) % MOD;
        return WIDTH'(bm ^ (bm >> 1));
    endfunction

    // inverse by search: the binary value whose Gray code matches
    function automatic int g2b(input logic [WIDTH-1:0] g);
        for (int b = 0; b < MOD; b++) begin
            if (b2g(b) == g) return b;
        end
        return -1;
    endfunction

    task automatic pulse_clear();
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || bin_out !== '0 || dir !== 2'b00 ||
            step_err !== 1'b0 || err_count !== '0) begin
            errors++;
            $display("FAIL reset_state: ov=%b bin=%h dir=%b err=%b cnt=%0d, required all zero",
                     out_valid, bin_out, dir, step_err, err_count);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk); in_valid = 1'b1; gray_in = 4'b0001;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || bin_out !== 4'b0001 || dir !== 2'b00) begin
            errors++;
            $display("FAIL single_decode: ov=%b bin=%b dir=%b, required 1 0001 00", out_valid, bin_out, dir);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || bin_out !== 4'b0001) begin
            errors++;
            $display("FAIL single_hold: ov=%b bin=%b, required 0 0001", out_valid, bin_out);
        end
        pulse_clear();
        in_valid = 1'b1; gray_in = 4'b1000;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || bin_out !== 4'b1111 || dir !== 2'b00 || step_err !== 1'b0) begin
            errors++;
            $display("FAIL single_first_1000: ov=%b bin=%b dir=%b err=%b, required 1 1111 00 0",
                     out_valid, bin_out, dir, step_err);
        end
    endtask

    task automatic test_up_stream();
        logic [3:0] g  [5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110};
        logic [3:0] eb [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        logic [1:0] ed [5] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
        pulse_clear();
        for (int i = 0; i <= 6; i++) begin
            if (i > 0) @(negedge clk);
            if (i >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || bin_out !== eb[i-2] || dir !== ed[i-2] || step_err !== 1'b0) begin
                    errors++;
                    $display("FAIL up_stream[%0d]: ov=%b bin=%0d dir=%b err=%b, required 1 %0d %b 0",
                             i-2, out_valid, bin_out, dir, step_err, eb[i-2], ed[i-2]);
                end
            end
            in_valid = (i < 5);
            if (i < 5) gray_in = g[i];
        end
    endtask

    task automatic test_wrap_down();
        logic [3:0] g  [3] = '{4'b1000, 4'b0000, 4'b1000};
        logic [3:0] eb [3] = '{4'd15, 4'd0, 4'd15};
        logic [1:0] ed [3] = '{2'b00, 2'b01, 2'b10};
        pulse_clear();
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) @(negedge clk);
            if (i >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || bin_out !== eb[i-2] || dir !== ed[i-2] || step_err !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap_down[%0d]: ov=%b bin=%0d dir=%b err=%b, required 1 %0d %b 0",
                             i-2, out_valid, bin_out, dir, step_err, eb[i-2], ed[i-2]);
                end
            end
            in_valid = (i < 3);
            if (i < 3) gray_in = g[i];
        end
    endtask

    task automatic test_step_error();
        logic [3:0] g  [3] = '{4'b0001, 4'b0010, 4'b0110};
        logic [3:0] eb [3] = '{4'd1, 4'd3, 4'd4};
        logic [1:0] ed [3] = '{2'b00, 2'b11, 2'b01};
        logic       ee [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0] ec [3] = '{2'd0, 2'd1, 2'd1};
        pulse_clear();
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) @(negedge clk);
            if (i >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || bin_out !== eb[i-2] || dir !== ed[i-2] ||
                    step_err !== ee[i-2] || err_count !== ec[i-2]) begin
                    errors++;
                    $display("FAIL step_error[%0d]: ov=%b bin=%0d dir=%b err=%b cnt=%0d, required 1 %0d %b %b %0d",
                             i-2, out_valid, bin_out, dir, step_err, err_count, eb[i-2], ed[i-2], ee[i-2], ec[i-2]);
                end
            end
            in_valid = (i < 3);
            if (i < 3) gray_in = g[i];
        end
    endtask

    task automatic test_saturation_clear();
        logic [1:0] ec [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        pulse_clear();
        for (int i = 0; i <= 7; i++) begin
            if (i > 0) @(negedge clk);
            if (i >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || bin_out !== 4'(2*(i-2)) || err_count !== ec[i-2] ||
                    step_err !== (i > 2) || dir !== ((i > 2) ? 2'b11 : 2'b00)) begin
                    errors++;
                    $display("FAIL saturation[%0d]: ov=%b bin=%0d dir=%b err=%b cnt=%0d, required cnt %0d",
                             i-2, out_valid, bin_out, dir, step_err, err_count, ec[i-2]);
                end
            end
            in_valid = (i < 6);
            if (i < 6) gray_in = b2g(2*i);
        end
        pulse_clear();
        checks++;
        if (err_count !== '0) begin
            errors++;
            $display("FAIL clear_count: cnt=%0d, required 0", err_count);
        end
        in_valid = 1'b1; gray_in = b2g(0);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || bin_out !== 4'd0 || dir !== 2'b00 || step_err !== 1'b0) begin
            errors++;
            $display("FAIL clear_first: ov=%b bin=%0d dir=%b err=%b, required 1 0 00 0",
                     out_valid, bin_out, dir, step_err);
        end
    endtask

    task automatic test_clear_same_edge();
        pulse_clear();
        in_valid = 1'b1; gray_in = b2g(2);
        @(negedge clk); gray_in = b2g(9);
        @(negedge clk); gray_in = b2g(10); clear = 1'b1;
        @(negedge clk); in_valid = 1'b0; clear = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || bin_out !== 4'd9 || dir !== 2'b00 ||
            step_err !== 1'b0 || err_count !== '0) begin
            errors++;
            $display("FAIL clear_same_edge: ov=%b bin=%0d dir=%b err=%b cnt=%0d, required 1 9 00 0 0",
                     out_valid, bin_out, dir, step_err, err_count);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || bin_out !== 4'd10 || dir !== 2'b00 || step_err !== 1'b0) begin
            errors++;
            $display("FAIL clear_keeps_s1: ov=%b bin=%0d dir=%b err=%b, required 1 10 00 0",
                     out_valid, bin_out, dir, step_err);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); in_valid = 1'b1; gray_in = b2g(7);
        @(negedge clk); gray_in = b2g(12);
        @(negedge clk); in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || bin_out !== 4'd7) begin
            errors++;
            $display("FAIL pre_reset: ov=%b bin=%0d, required 1 7", out_valid, bin_out);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || bin_out !== '0 || dir !== 2'b00 ||
            step_err !== 1'b0 || err_count !== '0) begin
            errors++;
            $display("FAIL async_reset: ov=%b bin=%0d dir=%b err=%b cnt=%0d, required all zero",
                     out_valid, bin_out, dir, step_err, err_count);
        end
        @(negedge clk); reset = 1'b0;
        in_valid = 1'b1; gray_in = b2g(3);
        @(negedge clk); in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL inflight_dropped: ov=%b, required 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || bin_out !== 4'd3 || dir !== 2'b00 || step_err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_first: ov=%b bin=%0d dir=%b err=%b, required 1 3 00 0",
                     out_valid, bin_out, dir, step_err);
        end
    endtask

    task automatic test_random_stream();
        bit       pv = 0;
        bit       v, clr;
        int       pb = 0;
        int       last_drv = 0;
        int       b, d;
        bit       have_exp = 0, have_bin = 0;
        bit       e_v, e_err;
        int       e_bin = 0, e_cnt = 0;
        logic [1:0] e_dir;
        pulse_clear();
        m_first = 1; m_prev = 0; m_cnt = 0;
        for (int i = 0; i < 402; i++) begin
            if (i > 0) @(negedge clk);
            if (have_exp) begin
                checks++;
                if (out_valid !== e_v || (have_bin && bin_out !== WIDTH'(e_bin)) ||
                    dir !== e_dir || step_err !== e_err || err_count !== ERR_W'(e_cnt)) begin
                    errors++;
                    $display("FAIL random[%0d]: ov=%b bin=%0d dir=%b err=%b cnt=%0d, required %b %0d %b %b %0d",
                             i, out_valid, bin_out, dir, step_err, err_count, e_v, e_bin, e_dir, e_err, e_cnt);
                end
            end
            clr = (i < 400) && ($urandom_range(0, 19) == 0);
            v   = (i < 400) && ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 3) == 0) b = $urandom_range(0, MOD-1);
            else b = ((last_drv + $urandom_range(0, 2) - 1) % MOD + MOD) % MOD;
            // expectation for the sample driven last cycle, seen next cycle
            e_v = pv; e_dir = 2'b00; e_err = 0;
            if (clr) m_cnt = 0;
            if (pv) begin
                e_bin = pb; have_bin = 1;
                if (!m_first && !clr) begin
                    d = ((pb - m_prev) % MOD + MOD) % MOD;
                    if (d == 0) e_dir = 2'b00;
                    else if (d == 1) e_dir = 2'b01;
                    else if (d == MOD-1) e_dir = 2'b10;
                    else begin
                        e_dir = 2'b11; e_err = 1;
                        if (m_cnt < CMAX) m_cnt++;
                    end
                end
                m_prev = pb;
                m_first = clr;
            end else if (clr) begin
                m_first = 1;
            end
            e_cnt = m_cnt;
            have_exp = 1;
            pv = v;
            if (v) begin
                pb = b; last_drv = b;
                if (g2b(b2g(b)) != b) $fatal(1, "FAIL model_inverse: b=%0d", b);
            end
            in_valid = v; gray_in = b2g(b); clear = clr;
        end
        in_valid = 1'b0; clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_up_stream();
        test_wrap_down();
        test_step_error();
        test_saturation_clear();
        test_clear_same_edge();
        test_reset_mid();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gray_decoder.md
# gray_decoder

Registered Gray-to-binary decoder: the receive end of the 4-bit Gray code path produced by `grey_code`. It accepts a stream of Gray-coded samples, converts each to binary through a two-stage pipeline, and checks that consecutive samples differ by exactly one code step (±1 mod 2^WIDTH). It sits downstream of Gray-coded counters and pointers and flags corrupted or skipped codes.

## Interface

- `WIDTH`, 4, code width in bits (≥2)
- `ERR_W`, 8, width of the saturating error counter

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  `gray_in` holds a sample this cycle
- `gray_in`  in  WIDTH  Gray-coded sample, MSB = bit WIDTH-1
- `clear`  in  1  synchronous: drop the step reference and zero `err_count`
- `out_valid`  out  1  `bin_out`/`dir`/`step_err` valid this cycle
- `bin_out`  out  WIDTH  binary value of the sample
- `dir`  out  2  00 = first/hold, 01 = up (+1), 10 = down (−1), 11 = invalid step
- `step_err`  out  1  pulse: sample is not within ±1 (or equal) of the previous sample
- `err_count`  out  ERR_W  saturating count of `step_err` pulses

## Operation

- Conversion: `bin[WIDTH-1] = g[WIDTH-1]`; `bin[i] = bin[i+1] ^ g[i]` for i = WIDTH-2 down to 0.
- Stage 1 (S1): on a clock edge with `in_valid`=1, register `gray_in` and set `s1_v`=1; otherwise `s1_v`=0.
- Stage 2 (S2): when `s1_v`=1, register the converted value to `bin_out`, assert `out_valid`, compute `dir`/`step_err`, then update `prev_bin`.
- Tracking FSM, two states:
  - FIRST: entered from reset or `clear`. The next S2 sample gets `dir`=00 and `step_err`=0, loads `prev_bin`, and moves the FSM to TRACK.
  - TRACK: delta = `bin − prev_bin` mod 2^WIDTH. Delta 0 gives `dir`=00; delta 1 gives 01; delta 2^WIDTH−1 gives 10. Any other delta gives `dir`=11 and `step_err`=1. `prev_bin` updates on every sample, including error samples, so the FSM resynchronizes to the new value. The FSM stays in TRACK.
- Wrap-around is legal: all-ones binary to 0 is up; 0 to all-ones binary is down.
- `err_count` increments by 1 on each `step_err` and holds at 2^ERR_W−1 once saturated.
- `clear` has priority over a same-edge S2 sample:
  - The FSM goes to FIRST and `err_count` goes to 0.
  - That S2 sample still drives `out_valid`/`bin_out`, with `dir`=00 and `step_err`=0.
  - The S1 contents are kept.

## Timing

- Latency: a sample captured at edge k appears on the outputs after edge k+1, so `out_valid` is high for the cycle following edge k+1.
- Back-to-back `in_valid` gives one output per cycle. There is no stall and no backpressure.
- `out_valid`, `step_err`, and `dir` are single-cycle qualifiers. `bin_out` holds its last value while `out_valid`=0.
- Reset (asynchronous, at any time, including mid-stream):
  - `out_valid`=0, `bin_out`=0, `dir`=00, `step_err`=0, `err_count`=0.
  - `s1_v`=0, `prev_bin`=0, FSM=FIRST.
  - In-flight samples are discarded.
  - The first sample after reset deasserts is treated as FIRST.

## Test plan

- Single decode: `gray_in`=0001 with `in_valid` for 1 cycle. Required: 2 edges later `bin_out`=0001, `out_valid`=1, `dir`=00. Also `gray_in`=1000 as a fresh FIRST sample gives `bin_out`=1111.
- Up stream: back-to-back 0000, 0001, 0011, 0010, 0110. Required: `bin_out` = 0, 1, 2, 3, 4 on consecutive cycles; `dir` = 00, 01, 01, 01, 01; `step_err` never asserts.
- Wrap and down: sequence 1000, 0000, 1000. Required: bins 15, 0, 15; `dir` = 00, 01, 10.
- Step error: sequence 0001, 0010, 0110. Required:
  - bins 1, 3, 4.
  - Second sample: `dir`=11, `step_err`=1, `err_count`=1.
  - Third sample: `dir`=01, since the FSM resynchronized to 3.
- Saturation and clear, with ERR_W=2: drive 5 erroneous steps. Required: `err_count` reaches 3 and holds. Then pulse `clear`: `err_count`=0, and the next sample gets `dir`=00.
- Reset mid-operation: assert `reset` between edges while a sample is in S1. Required: outputs go to 0 immediately without waiting for a clock edge, and no `out_valid` appears for the in-flight sample. The next sample after reset reports `dir`=00.
